gpio_port_unit: RTL and testbench

- Datapath block directly downstream of the control FSM.
- Consumes the FSM's 8-bit `state` bus and executes the GPIO store states (`STATE_MIN_STORE`, `STATE_MOUT_STORE`, `STATE_RIN_STORE`, `STATE_ROUT_STORE`, encodings from symbols.vh).
- Buffers external input bytes in a small FIFO and drives external output bytes through a valid/ready handshake.
- The FSM has no stall input, so this unit never back-pressures the CPU: it buffers, or drops and flags.

---
 rtl/gpio_port_unit.sv | 117 +++++++++++
 tb/tb_gpio_port_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gpio_port_unit.sv
// GPIO datapath behind the control FSM: input byte FIFO for MIN/RIN, output
// register plus one pending slot for MOUT/ROUT. The CPU is never stalled.
module gpio_port_unit #(
   parameter int          DATA_W          = 8,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          AW              = 2,
   parameter logic [7:0]  STATE_NEXT       = 8'h01,
   parameter logic [7:0]  STATE_MIN_STORE  = 8'h10,
   parameter logic [7:0]  STATE_MOUT_STORE = 8'h11,
   parameter logic [7:0]  STATE_RIN_STORE  = 8'h12,
   parameter logic [7:0]  STATE_ROUT_STORE = 8'h13
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        state,
   input  logic [DATA_W-1:0] bus_in,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_out_en,
   input  logic [DATA_W-1:0] gpio_in_data,
   input  logic              gpio_in_valid,
   output logic              gpio_in_ready,
   output logic [DATA_W-1:0] gpio_out_data,
   output logic              gpio_out_valid,
   input  logic              gpio_out_ready,
   output logic [7:0]        status
);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wptr_q, rptr_q;
   logic [AW:0]       cnt_q, cnt_d;
   logic              served_q, unf_q, ovf_q;
   logic [DATA_W-1:0] out_data_q, pend_q;
   logic              out_vld_q, pend_full_q;

   logic rd, wr, push, pop, xfer, fifo_empty;

   // served_q makes each store state act once, even when the FSM dwells in it
   assign rd   = ((state == STATE_MIN_STORE) || (state == STATE_RIN_STORE)) && !served_q;
   assign wr   = ((state == STATE_MOUT_STORE) || (state == STATE_ROUT_STORE)) && !served_q;
   assign fifo_empty    = (cnt_q == '0);
   assign gpio_in_ready = (cnt_q != (AW+1)'(FIFO_DEPTH));
   assign push = gpio_in_valid && gpio_in_ready;
   assign pop  = rd && !fifo_empty;
   assign xfer = out_vld_q && gpio_out_ready;

   always_comb begin
      bus_out    = '0;
      bus_out_en = 1'b0;
      if (rd) begin
         bus_out_en = 1'b1;
         if (!fifo_empty) bus_out = mem_q[rptr_q];
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= gpio_in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         served_q <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (rd && fifo_empty) unf_q <= 1'b1;
         if (state == STATE_NEXT) served_q <= 1'b0;
         else if (rd || wr)       served_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q  <= '0;
         out_vld_q   <= 1'b0;
         pend_q      <= '0;
         pend_full_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (xfer) begin
         // the pending byte, if any, takes precedence over a new write
         if (pend_full_q) begin
            out_data_q <= pend_q;
            if (wr) pend_q <= bus_in;
            else    pend_full_q <= 1'b0;
         end else if (wr) begin
            out_data_q <= bus_in;
         end else begin
            out_vld_q <= 1'b0;
         end
      end else if (wr) begin
         if (!out_vld_q) begin
            out_data_q <= bus_in;
            out_vld_q  <= 1'b1;
         end else if (!pend_full_q) begin
            pend_q      <= bus_in;
            pend_full_q <= 1'b1;
         end else begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign gpio_out_data  = out_data_q;
   assign gpio_out_valid = out_vld_q;
   assign status = {{(4-(AW+1)){1'b0}}, cnt_q, 1'b0, ovf_q, unf_q, out_vld_q | pend_full_q};

endmodule

// File: tb/tb_gpio_port_unit.sv
// Directed bench for gpio_port_unit; inputs change at posedge+1, checks at posedge+2.
module tb_gpio_port_unit;
   localparam logic [7:0] S_IDLE = 8'h00, S_NEXT = 8'h01, S_MIN = 8'h10,
                          S_MOUT = 8'h11, S_RIN = 8'h12, S_ROUT = 8'h13;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] state, bus_in, bus_out, gpio_in_data, gpio_out_data, status;
   logic       bus_out_en, gpio_in_valid, gpio_in_ready, gpio_out_valid, gpio_out_ready;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpio_port_unit #(
      .DATA_W(8), .FIFO_DEPTH(4), .AW(2),
      .STATE_NEXT(S_NEXT), .STATE_MIN_STORE(S_MIN), .STATE_MOUT_STORE(S_MOUT),
      .STATE_RIN_STORE(S_RIN), .STATE_ROUT_STORE(S_ROUT)
   ) dut (
      .clk(clk), .reset(reset), .state(state), .bus_in(bus_in),
      .bus_out(bus_out), .bus_out_en(bus_out_en),
      .gpio_in_data(gpio_in_data), .gpio_in_valid(gpio_in_valid), .gpio_in_ready(gpio_in_ready),
      .gpio_out_data(gpio_out_data), .gpio_out_valid(gpio_out_valid), .gpio_out_ready(gpio_out_ready),
      .status(status)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d);
      gpio_in_data = d; gpio_in_valid = 1'b1;
      tick();
      gpio_in_valid = 1'b0;
   endtask

   // one MIN_STORE cycle followed by NEXT, checking the returned byte
   task automatic read_byte(input string tag, input logic [7:0] exp);
      state = S_MIN; settle();
      chk(tag, {bus_out_en, bus_out}, {1'b1, exp});
      tick();
      state = S_NEXT;
      tick();
   endtask

   task automatic write_byte(input logic [7:0] st, input logic [7:0] d);
      state = st; bus_in = d;
      tick();
      state = S_NEXT;
      tick();
   endtask

   initial begin
      reset = 1'b1; state = S_IDLE; bus_in = '0; gpio_in_data = '0;
      gpio_in_valid = 1'b0; gpio_out_ready = 1'b0;
      tick(); tick();
      reset = 1'b0; settle();
      chk("rst_ready", gpio_in_ready, 1);
      chk("rst_bus", {bus_out_en, bus_out}, 0);
      chk("rst_status", status, 0);
      chk("rst_ovalid", gpio_out_valid, 0);
      chk("rst_odata", gpio_out_data, 0);

      // single push and RIN read
      push_byte(8'hA5); settle();
      chk("cnt1", status[7:4], 1);
      state = S_RIN; settle();
      chk("rin_a5", {bus_out_en, bus_out}, {1'b1, 8'hA5});
      tick();
      state = S_NEXT; settle();
      chk("cnt0", status[7:4], 0);
      chk("next_en", bus_out_en, 0);
      tick();

      // fill, hold off a fifth byte, free a slot with a read
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      settle();
      chk("full_ready", gpio_in_ready, 0);
      chk("full_cnt", status[7:4], 4);
      gpio_in_data = 8'h05; gpio_in_valid = 1'b1;
      tick();
      chk("held_cnt", status[7:4], 4);
      state = S_MIN; settle();
      chk("min_01", {bus_out_en, bus_out}, {1'b1, 8'h01});
      tick();
      state = S_NEXT; settle();
      chk("ready_back", gpio_in_ready, 1);
      chk("cnt3", status[7:4], 3);
      tick();
      gpio_in_valid = 1'b0; settle();
      chk("cnt4_again", status[7:4], 4);
      read_byte("ord_02", 8'h02);
      read_byte("ord_03", 8'h03);
      read_byte("ord_04", 8'h04);
      read_byte("ord_05", 8'h05);

      // underflow
      chk("pre_unf", status[1], 0);
      state = S_RIN; settle();
      chk("unf_bus", {bus_out_en, bus_out}, {1'b1, 8'h00});
      tick();
      state = S_NEXT; settle();
      chk("unf_flag", status[1], 1);
      chk("unf_cnt", status[7:4], 0);
      tick();

      // output buffering and overflow
      gpio_out_ready = 1'b0;
      write_byte(S_ROUT, 8'h11);
      write_byte(S_MOUT, 8'h22);
      chk("pre_ovf", status[2], 0);
      write_byte(S_ROUT, 8'h33);
      chk("out_11", {gpio_out_valid, gpio_out_data}, {1'b1, 8'h11});
      chk("busy", status[0], 1);
      chk("ovf", status[2], 1);
      gpio_out_ready = 1'b1;
      tick();
      chk("out_22", {gpio_out_valid, gpio_out_data}, {1'b1, 8'h22});
      chk("busy_22", status[0], 1);
      tick();
      chk("out_done", gpio_out_valid, 0);
      chk("idle", status[0], 0);
      gpio_out_ready = 1'b0;

      // held store state pops only once
      push_byte(8'h10); push_byte(8'h20);
      state = S_MIN; settle();
      chk("hold_10", {bus_out_en, bus_out}, {1'b1, 8'h10});
      tick();
      chk("hold_quiet", bus_out_en, 0);
      tick(); tick();
      chk("hold_cnt", status[7:4], 1);
      state = S_NEXT; tick();
      read_byte("after_next_20", 8'h20);
      chk("hold_empty", status[7:4], 0);

      // reset mid-handshake
      write_byte(S_ROUT, 8'h55);
      push_byte(8'hC1); push_byte(8'hC2); settle();
      chk("pre_rst_valid", gpio_out_valid, 1);
      chk("pre_rst_cnt", status[7:4], 2);
      reset = 1'b1; tick();
      reset = 1'b0; settle();
      chk("rst2_valid", gpio_out_valid, 0);
      chk("rst2_status", status, 0);
      chk("rst2_ready", gpio_in_ready, 1);
      chk("rst2_odata", gpio_out_data, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
